// File: rtl/burst_mem_pkg.sv
// Shared types and constants for the burst memory responder.
package burst_mem_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    BURST = 2'd2,
    DONE  = 2'd3
  } bm_state_e;

  localparam int BEATS       = 4;
  localparam int BEAT_W      = 64;
  localparam int LINE_W      = 256;
  localparam int OFFSET_BITS = 5;

endpackage

// File: rtl/burst_mem_array.sv
// Word-addressed 1R1W backing store: asynchronous read, synchronous write.
// Contents are never reset.
module burst_mem_array
  import burst_mem_pkg::*;
#(
  parameter int    DEPTH_LOG2 = 8,
  parameter string INIT_FILE  = ""
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [DEPTH_LOG2+1:0] waddr,
  input  logic [BEAT_W-1:0]     wdata,
  input  logic [DEPTH_LOG2+1:0] raddr,
  output logic [BEAT_W-1:0]     rdata
);

  logic [BEAT_W-1:0] mem [2**(DEPTH_LOG2+2)];

  // Commit one beat per write-enabled edge.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/burst_mem_responder.sv
// Memory-side responder for the four-beat 64-bit line burst protocol.
// Optional protocol checker enabled by defining BURST_MEM_PROTOCOL_CHECK_EN;
// without it err is tied low.
//
// state | meaning
// IDLE  | waiting for mem_read/mem_write
// WAIT  | access latency countdown (lat_cnt)
// BURST | four beats, mem_resp high, beat 0..3
// DONE  | one gap cycle with mem_resp low
module burst_mem_responder
  import burst_mem_pkg::*;
#(
  parameter int    DEPTH_LOG2 = 8,
  parameter int    LATENCY    = 4,
  parameter string INIT_FILE  = ""
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [31:0]       mem_addr,
  input  logic [BEAT_W-1:0] mem_wdata,
  output logic [BEAT_W-1:0] mem_rdata,
  output logic              mem_resp,
  output logic              err
);

  localparam logic [7:0] LAT_INIT = 8'(LATENCY - 1);

  bm_state_e             state;
  logic [DEPTH_LOG2-1:0] idx;
  logic                  op_read;
  logic [7:0]            lat_cnt;
  logic [1:0]            beat;
  logic                  req;
  logic [DEPTH_LOG2+1:0] word_addr;
  logic [BEAT_W-1:0]     rd_word;
  logic                  unused_addr;

  assign req         = mem_read | mem_write;
  assign word_addr   = {idx, beat};
  assign unused_addr = ^{mem_addr[31:OFFSET_BITS+DEPTH_LOG2], mem_addr[OFFSET_BITS-1:0]};

  // Sequencer: accept, count latency, stream four beats, one gap cycle.
  // The edge closing DONE doubles as an acceptance point, so a held request
  // restarts LATENCY+5 cycles after the previous acceptance.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      idx     <= '0;
      op_read <= 1'b0;
      lat_cnt <= '0;
      beat    <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (req) begin
            idx     <= mem_addr[OFFSET_BITS +: DEPTH_LOG2];
            op_read <= mem_read;
            lat_cnt <= LAT_INIT;
            state   <= WAIT;
          end else begin
            state <= IDLE;
          end
        end
        WAIT: begin
          if (lat_cnt == 8'd0) begin
            beat  <= '0;
            state <= BURST;
          end else begin
            lat_cnt <= lat_cnt - 8'd1;
          end
        end
        BURST: begin
          beat <= beat + 2'd1;
          if (beat == 2'(BEATS - 1)) state <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign mem_resp  = (state == BURST);
  assign mem_rdata = (mem_resp && op_read) ? rd_word : '0;

  burst_mem_array #(
    .DEPTH_LOG2(DEPTH_LOG2),
    .INIT_FILE (INIT_FILE)
  ) u_array (
    .clk  (clk),
    .we   (mem_resp && !op_read),
    .waddr(word_addr),
    .wdata(mem_wdata),
    .raddr(word_addr),
    .rdata(rd_word)
  );

`ifdef BURST_MEM_PROTOCOL_CHECK_EN
  logic [31-OFFSET_BITS:0] addr_hi;
  logic                    busy;
  logic                    viol_both;
  logic                    viol_addr;
  logic                    viol_drop;

  assign busy      = (state == WAIT) || (state == BURST);
  assign viol_both = mem_read && mem_write && ((state == IDLE) || busy);
  assign viol_addr = busy && (mem_addr[31:OFFSET_BITS] != addr_hi);
  assign viol_drop = busy && !(op_read ? mem_read : mem_write) &&
                     !((state == BURST) && (beat == 2'(BEATS - 1)));

  // Track the accepted line address and latch any violation until reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      addr_hi <= '0;
      err     <= 1'b0;
    end else begin
      if (((state == IDLE) || (state == DONE)) && req) addr_hi <= mem_addr[31:OFFSET_BITS];
      if (viol_both || viol_addr || viol_drop) err <= 1'b1;
    end
  end

`ifndef SYNTHESIS
  // Simulation-only report of each violation.
  always @(posedge clk) begin
    if (reset_n && viol_both) $error("burst_mem_responder: read and write both asserted");
    if (reset_n && viol_addr) $error("burst_mem_responder: mem_addr changed mid-transaction");
    if (reset_n && viol_drop) $error("burst_mem_responder: request dropped before last beat");
  end
`endif
`else
  assign err = 1'b0;
`endif

endmodule
